// File: rtl/upsample_frame_sequencer.sv
// Frame sequencer between the upsampling datapath and the 2x BMP writer.
// Accepts packed 2x2 quads on a valid/ready stream, forwards them to the
// writer's din/vld strobe, tracks row/col, bounds each frame to
// WIDTH*HEIGHT quads and holds off the next frame until the writer is done
// and a settle gap has elapsed.
module upsample_frame_sequencer #(
  parameter int WI      = 32,
  parameter int WIDTH   = 128,
  parameter int HEIGHT  = 128,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          cont,
  input  logic [WI-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [WI-1:0] wr_din,
  output logic          wr_vld,
  input  logic          wr_frame_done,
  output logic [11:0]   row,
  output logic [11:0]   col,
  output logic          busy,
  output logic          frame_end,
  output logic [15:0]   frames_done,
  output logic          err_start,
  output logic          err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP + 1);

  localparam logic [11:0]       LAST_COL  = 12'(WIDTH - 1);
  localparam logic [11:0]       LAST_ROW  = 12'(HEIGHT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_DONE  = GAP_W'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WI-1:0]     r_wr_din;
  logic              r_wr_vld;
  logic [11:0]       r_row;
  logic [11:0]       r_col;
  logic              r_frame_end;
  logic [15:0]       r_frames_done;
  logic              r_err_start;
  logic              r_err_timeout;
  logic [WAIT_W-1:0] r_wait;
  logic [GAP_W-1:0]  r_gap;

  logic              w_accept;
  logic              w_last;
  logic              w_clear;
  logic              w_timeout;
  logic              w_retire;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle event strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_clear     = 1'b0;
    w_timeout   = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_clear     = 1'b1;
        end
      end
      S_RUN: begin
        w_accept = s_valid;
        w_last   = s_valid && (r_row == LAST_ROW) && (r_col == LAST_COL);
        if (w_last) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wr_frame_done) begin
          w_state_nxt = S_GAP;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_GAP: begin
        // frame_end is registered, so the retire strobe fires on the last
        // gap count and the state lingers one more cycle; s_ready therefore
        // stays low through the frame_end cycle.
        if (r_gap == GAP_LAST) w_retire = 1'b1;
        if (r_gap == GAP_DONE) begin
          if (cont) begin
            w_state_nxt = S_RUN;
            w_clear     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: writer strobe, position, wait/gap counters, status and errors
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_din      <= '0;
      r_wr_vld      <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_frame_end   <= 1'b0;
      r_frames_done <= '0;
      r_err_start   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wait        <= '0;
      r_gap         <= '0;
    end else begin
      r_wr_vld <= w_accept;
      if (w_accept) r_wr_din <= s_data;

      if (w_clear || w_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + 12'd1;
        end else begin
          r_col <= r_col + 12'd1;
        end
      end

      r_wait <= (r_state == S_WAIT_DONE) ? r_wait + WAIT_W'(1) : '0;
      r_gap  <= (r_state == S_GAP)       ? r_gap + GAP_W'(1)   : '0;

      r_frame_end <= w_retire;
      if (w_retire) r_frames_done <= r_frames_done + 16'd1;

      if (start && (r_state != S_IDLE)) r_err_start <= 1'b1;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign s_ready     = (r_state == S_RUN);
  assign busy        = (r_state != S_IDLE);
  assign wr_din      = r_wr_din;
  assign wr_vld      = r_wr_vld;
  assign row         = r_row;
  assign col         = r_col;
  assign frame_end   = r_frame_end;
  assign frames_done = r_frames_done;
  assign err_start   = r_err_start;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_upsample_frame_sequencer.sv
// Bench for upsample_frame_sequencer: small 4x2 frames, randomized valid
// patterns and data, expectations derived from frame geometry and gap/timeout
// arithmetic.
module tb_upsample_frame_sequencer;

  localparam int WI      = 32;
  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 2;
  localparam int GAP     = 3;
  localparam int TIMEOUT = 16;
  localparam int FRAME   = WIDTH * HEIGHT;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          cont;
  logic [WI-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [WI-1:0] wr_din;
  logic          wr_vld;
  logic          wr_frame_done;
  logic [11:0]   row;
  logic [11:0]   col;
  logic          busy;
  logic          frame_end;
  logic [15:0]   frames_done;
  logic          err_start;
  logic          err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  upsample_frame_sequencer #(
    .WI(WI), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cont(cont),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_din(wr_din), .wr_vld(wr_vld), .wr_frame_done(wr_frame_done),
    .row(row), .col(col), .busy(busy), .frame_end(frame_end),
    .frames_done(frames_done), .err_start(err_start), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rstn = 1'b0; start = 1'b0; s_valid = 1'b0; cont = 1'b0;
    wr_frame_done = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
  task automatic begin_frame();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams quads from the first RUN cycle until stop_after quads are taken.
  // Expected position is k/WIDTH, k%WIDTH for the k-th quad of the frame;
  // each accepted quad must appear on the writer one cycle later.
  task automatic stream_frame(input string tag, input int mode,
                              input logic [31:0] base, input int start_at,
                              input int stop_after, output int vld_seen);
    int k;
    int cyc;
    bit prev_acc;
    bit have_data;
    bit started;
    logic [31:0] last_data;
    k = 0; cyc = 0; prev_acc = 1'b0; have_data = 1'b0; started = 1'b0;
    last_data = '0; vld_seen = 0;
    while (k < stop_after && cyc < 400) begin
      n_tests++;
      if (s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s s_ready k=%0d: got %b want 1", tag, k, s_ready);
      end
      n_tests++;
      if ({row, col} !== {12'(k / WIDTH), 12'(k % WIDTH)}) begin
        n_fail++;
        $display("FAIL %s row/col k=%0d: got %0d,%0d want %0d,%0d",
                 tag, k, row, col, k / WIDTH, k % WIDTH);
      end
      n_tests++;
      if (wr_vld !== prev_acc) begin
        n_fail++;
        $display("FAIL %s wr_vld k=%0d: got %b want %b", tag, k, wr_vld, prev_acc);
      end
      if (wr_vld === 1'b1) vld_seen++;
      if (have_data) begin
        n_tests++;
        if (wr_din !== last_data) begin
          n_fail++;
          $display("FAIL %s wr_din k=%0d: got %h want %h", tag, k, wr_din, last_data);
        end
      end
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 3 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = (mode == 0) ? base + 32'(k) : $urandom;
      if (k == start_at && !started) begin
        start   = 1'b1;
        started = 1'b1;
      end
      @(posedge clk);
      prev_acc = s_valid;
      if (s_valid) begin
        last_data = s_data;
        have_data = 1'b1;
        k++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    s_valid = 1'b0;
    if (k < stop_after) begin
      n_tests++; n_fail++;
      $display("FAIL %s stream timeout: accepted %0d want %0d", tag, k, stop_after);
    end
    n_tests++;
    if (wr_vld !== 1'b1 || wr_din !== last_data) begin
      n_fail++;
      $display("FAIL %s final quad: got vld=%b din=%h want vld=1 din=%h",
               tag, wr_vld, wr_din, last_data);
    end
    if (wr_vld === 1'b1) vld_seen++;
    if (stop_after == FRAME) begin
      n_tests++;
      if (s_ready !== 1'b0 || busy !== 1'b1 || row !== 12'd0 || col !== 12'd0) begin
        n_fail++;
        $display("FAIL %s after last: got ready=%b busy=%b row=%0d col=%0d want 0,1,0,0",
                 tag, s_ready, busy, row, col);
      end
    end
  endtask

  // Counts s_ready-low busy cycles after a frame and where frame_end appears.
  task automatic wait_retire(output int low, output int fe_at, output int fe_cnt);
    low = 0; fe_at = 0; fe_cnt = 0;
    while (s_ready === 1'b0 && busy === 1'b1 && low < 40) begin
      low++;
      if (frame_end === 1'b1) begin
        fe_cnt++;
        fe_at = low;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = 32'hFFFF_FFFF;
    cont = 1'b1; wr_frame_done = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({s_ready, wr_vld, busy, frame_end, err_start, err_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b want 000000",
               {s_ready, wr_vld, busy, frame_end, err_start, err_timeout});
    end
    n_tests++;
    if (wr_din !== '0 || row !== '0 || col !== '0 || frames_done !== '0) begin
      n_fail++;
      $display("FAIL reset values: got din=%h row=%0d col=%0d frames=%0d want 0",
               wr_din, row, col, frames_done);
    end
    start = 1'b0; s_valid = 1'b0; cont = 1'b0; wr_frame_done = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_single_frame();
    int vld, fe_at, fe_cnt;
    logic [15:0] fd_at;
    cont = 1'b0; wr_frame_done = 1'b0;
    start = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || wr_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single start: got busy=%b ready=%b vld=%b want 1,1,0",
               busy, s_ready, wr_vld);
    end
    stream_frame("single", 0, 32'h0302_0100, -1, FRAME, vld);
    n_tests++;
    if (vld != FRAME) begin
      n_fail++;
      $display("FAIL single vld count: got %0d want %0d", vld, FRAME);
    end
    @(negedge clk);
    n_tests++;
    if (frame_end !== 1'b0 || wr_vld !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single wait: got fe=%b vld=%b ready=%b want 0,0,0",
               frame_end, wr_vld, s_ready);
    end
    wr_frame_done = 1'b1;
    fe_at = 0; fe_cnt = 0; fd_at = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (frame_end === 1'b1) begin
        fe_cnt++;
        if (fe_at == 0) begin
          fe_at = i;
          fd_at = frames_done;
        end
      end
    end
    n_tests++;
    if (fe_at != GAP + 1 || fe_cnt != 1) begin
      n_fail++;
      $display("FAIL single frame_end: got at=%0d count=%0d want at=%0d count=1",
               fe_at, fe_cnt, GAP + 1);
    end
    n_tests++;
    if (fd_at !== 16'd1 || frames_done !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single frames_done: got %0d/%0d busy=%b want 1/1 busy=0",
               fd_at, frames_done, busy);
    end
    wr_frame_done = 1'b0;
  endtask

  task automatic test_bubbles();
    int vld, low, fe_at, fe_cnt;
    begin_frame();
    stream_frame("bubbles", 1, '0, -1, FRAME, vld);
    n_tests++;
    if (vld != FRAME) begin
      n_fail++;
      $display("FAIL bubbles vld count: got %0d want %0d", vld, FRAME);
    end
    wr_frame_done = 1'b1;
    wait_retire(low, fe_at, fe_cnt);
    n_tests++;
    if (low != GAP + 2 || fe_at != GAP + 2 || fe_cnt != 1 || frames_done !== 16'd2) begin
      n_fail++;
      $display("FAIL bubbles retire: got low=%0d fe_at=%0d fe=%0d frames=%0d want %0d,%0d,1,2",
               low, fe_at, fe_cnt, frames_done, GAP + 2, GAP + 2);
    end
    wr_frame_done = 1'b0;
  endtask

  task automatic test_random_frames();
    int vld, low, fe_at, fe_cnt, d;
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      stream_frame("random", 2, '0, -1, FRAME, vld);
      d = $urandom_range(0, 5);
      repeat (d) @(negedge clk);
      wr_frame_done = 1'b1;
      wait_retire(low, fe_at, fe_cnt);
      n_tests++;
      if (vld != FRAME || low != GAP + 2 || fe_at != GAP + 2 || fe_cnt != 1 ||
          frames_done !== 16'(3 + f)) begin
        n_fail++;
        $display("FAIL random frame %0d: got vld=%0d low=%0d fe_at=%0d fe=%0d frames=%0d want %0d,%0d,%0d,1,%0d",
                 f, vld, low, fe_at, fe_cnt, frames_done, FRAME, GAP + 2, GAP + 2, 3 + f);
      end
      wr_frame_done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int vld;
    bit bad;
    cont = 1'b0; wr_frame_done = 1'b0;
    begin_frame();
    stream_frame("timeout", 2, '0, -1, FRAME, vld);
    bad = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      n_tests++;
      if (busy !== 1'b1 || err_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout wait cycle %0d: got busy=%b err=%b want 1,0",
                 i, busy, err_timeout);
      end
      @(negedge clk);
    end
    n_tests++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 ||
        frames_done !== 16'd4 || frame_end !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout result: got err=%b busy=%b ready=%b frames=%0d fe=%b want 1,0,0,4,0",
               err_timeout, busy, s_ready, frames_done, frame_end);
    end
  endtask

  task automatic test_continuous();
    int vld, low, fe_at, fe_cnt, total_fe;
    apply_reset();
    cont = 1'b1; wr_frame_done = 1'b1; total_fe = 0;
    begin_frame();
    for (int f = 0; f < 3; f++) begin
      stream_frame("cont", 2, '0, -1, FRAME, vld);
      if (f == 2) cont = 1'b0;
      wait_retire(low, fe_at, fe_cnt);
      total_fe += fe_cnt;
      n_tests++;
      if (vld != FRAME || low != GAP + 2 || fe_at != GAP + 2) begin
        n_fail++;
        $display("FAIL cont frame %0d: got vld=%0d low=%0d fe_at=%0d want %0d,%0d,%0d",
                 f, vld, low, fe_at, FRAME, GAP + 2, GAP + 2);
      end
    end
    n_tests++;
    if (total_fe != 3 || frames_done !== 16'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont totals: got fe=%0d frames=%0d busy=%b want 3,3,0",
               total_fe, frames_done, busy);
    end
    wr_frame_done = 1'b0;
  endtask

  task automatic test_errors_and_reset();
    int vld, low, fe_at, fe_cnt;
    apply_reset();
    cont = 1'b0; wr_frame_done = 1'b1;
    begin_frame();
    n_tests++;
    if (err_start !== 1'b0) begin
      n_fail++;
      $display("FAIL err_start initial: got %b want 0", err_start);
    end
    stream_frame("err_start", 2, '0, 3, FRAME, vld);
    n_tests++;
    if (err_start !== 1'b1 || vld != FRAME) begin
      n_fail++;
      $display("FAIL err_start set: got err=%b vld=%0d want 1,%0d", err_start, vld, FRAME);
    end
    wait_retire(low, fe_at, fe_cnt);
    n_tests++;
    if (low != GAP + 2 || frames_done !== 16'd1 || err_start !== 1'b1) begin
      n_fail++;
      $display("FAIL err_start frame: got low=%0d frames=%0d err=%b want %0d,1,1",
               low, frames_done, err_start, GAP + 2);
    end
    begin_frame();
    stream_frame("midreset", 0, 32'hA0A0_A000, -1, 5, vld);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({s_ready, wr_vld, busy, frame_end, err_start, err_timeout} !== 6'b0 ||
        wr_din !== '0 || row !== '0 || col !== '0 || frames_done !== '0) begin
      n_fail++;
      $display("FAIL midreset: got flags=%b din=%h row=%0d col=%0d frames=%0d want all 0",
               {s_ready, wr_vld, busy, frame_end, err_start, err_timeout},
               wr_din, row, col, frames_done);
    end
    rstn = 1'b1;
    @(negedge clk);
    begin_frame();
    stream_frame("afterreset", 0, 32'h5500_0000, -1, FRAME, vld);
    wait_retire(low, fe_at, fe_cnt);
    n_tests++;
    if (vld != FRAME || fe_cnt != 1 || frames_done !== 16'd1) begin
      n_fail++;
      $display("FAIL afterreset frame: got vld=%0d fe=%0d frames=%0d want %0d,1,1",
               vld, fe_cnt, frames_done, FRAME);
    end
    wr_frame_done = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; cont = 1'b0; s_valid = 1'b0;
    s_data = '0; wr_frame_done = 1'b0;
    test_reset();
    test_single_frame();
    test_bubbles();
    test_random_frames();
    test_timeout();
    test_continuous();
    test_errors_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/upsample_frame_sequencer.md
# upsample_frame_sequencer

Frame-level controller sitting between the upsampling datapath and the 2x BMP output writer. It accepts packed 2x2 output quads (four 8-bit pixels per WI-bit word) over a valid/ready stream, paces them to the writer's `din`/`vld` interface, and tracks row/column position. Because the writer has no backpressure, the sequencer bounds each frame to exactly WIDTH×HEIGHT quads. It then holds off the next frame until the writer reports `frame_done` and a settle gap has elapsed.

## Interface
- WI, 32, quad word width (4×8-bit pixels, byte 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right)
- WIDTH, 128, quads per row (input-resolution columns)
- HEIGHT, 128, quad rows per frame
- GAP, 4, idle cycles after writer `frame_done` before the frame is retired (≥1)
- TIMEOUT, 1024, max cycles to wait for writer `frame_done` (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, reset is synchronous and active-low
- start  in  1  single-cycle frame start request
- cont  in  1  continuous mode; sampled when leaving GAP
- s_data  in  WI  upstream quad
- s_valid  in  1  upstream quad valid
- s_ready  out  1  sequencer accepts a quad this cycle
- wr_din  out  WI  quad to writer
- wr_vld  out  1  writer strobe
- wr_frame_done  in  1  writer frame-complete level
- row  out  12  row index of next quad to accept
- col  out  12  column index of next quad to accept
- busy  out  1  state ≠ IDLE
- frame_end  out  1  one-cycle pulse on frame retirement
- frames_done  out  16  retired-frame counter
- err_start  out  1  sticky: `start` seen while busy
- err_timeout  out  1  sticky: writer did not finish within TIMEOUT

## Operation
States are IDLE, RUN, WAIT_DONE and GAP.

- **IDLE:** `s_ready` = 0.
  - `start` = 1 → RUN.
  - row, col and the internal counters clear on entry to RUN.
- **RUN:** `s_ready` = 1, decoded from the state register only; it has no combinational dependency on `s_valid`.
  - Accept = `s_valid` & `s_ready`.
  - On accept, `wr_din` ← `s_data` and `wr_vld` ← 1 on the next edge. Otherwise `wr_vld` ← 0 and `wr_din` holds its value.
  - col increments on each accept. At col = WIDTH-1, col → 0 and row increments.
  - Accepting the quad at (HEIGHT-1, WIDTH-1) → WAIT_DONE, with row and col → 0.
- **WAIT_DONE:** `s_ready` = 0 and a wait counter runs.
  - The sampled `wr_frame_done` = 1 → GAP. Only the level is checked, because the writer holds `frame_done` high once set.
  - Wait counter reaches TIMEOUT-1 → set `err_timeout`, go to IDLE. `frames_done` does not increment.
- **GAP:** `s_ready` = 0; count GAP cycles. On the last cycle:
  - pulse `frame_end`;
  - `frames_done` += 1, wrapping 65535 → 0;
  - go to RUN if `cont` = 1 (counters cleared), else IDLE.
- `start` in any state other than IDLE is ignored and sets `err_start`.
- `err_start` and `err_timeout` clear only on reset.
- `start` and `s_valid` on the same cycle in IDLE: the quad is not accepted, because `s_ready` is still 0.

## Timing
- Reset values:
  - state = IDLE;
  - `s_ready`, `wr_vld`, `busy`, `frame_end`, `err_start`, `err_timeout` = 0;
  - `wr_din`, row, col, `frames_done` = 0.
- Reset asserted mid-frame: on the next edge every output takes its reset value and the in-flight `wr_vld` is dropped. No partial-frame recovery is performed.
- `start` at edge N → `busy` = 1 and `s_ready` = 1 from N+1.
- Accept at edge N → `wr_vld` high for the cycle after N, carrying that quad.
- Sustained throughput is 1 quad per cycle. A frame takes WIDTH×HEIGHT accept cycles.
- Last accept at edge N → `s_ready` = 0 from N+1. The final `wr_vld` is high in the same cycle.
- `wr_frame_done` seen high in WAIT_DONE at edge M → `frame_end` pulses in the cycle after edge M+GAP.
- With `cont` = 1, `s_ready` returns one cycle after `frame_end`.
- row and col always reflect the position of the next quad to be accepted.

## Test plan
Bench parameters: WIDTH = 4, HEIGHT = 2, GAP = 3, TIMEOUT = 16.

- **Single frame:** reset, `start`, 8 quads 0x03020100 + k with `s_valid` held high → exactly 8 `wr_vld` pulses, each one cycle after its accept, carrying the same data. `s_ready` drops after the 8th quad. With `wr_frame_done` raised 2 cycles later, `frame_end` pulses 3 cycles after it is seen and `frames_done` = 1.
- **Bubbles:** `s_valid` toggles 1,0,0,1,… → `wr_vld` count = 8. row/col sequence is (0,0)…(1,3) then (0,0). No duplicated or dropped data.
- **Timeout:** full frame, `wr_frame_done` held 0 → after 16 WAIT_DONE cycles `err_timeout` = 1, state IDLE, `frames_done` unchanged.
- **Continuous:** `cont` = 1, `wr_frame_done` = 1 throughout, 24 quads offered → 3 `frame_end` pulses and `frames_done` = 3. `s_ready` is low for exactly 1 + 3 + 1 cycles between frames (WAIT_DONE, GAP, `frame_end` cycle).
- **Errors and reset:** `start` pulsed during RUN → `err_start` = 1 and the frame continues unaffected. `rstn` = 0 after the 5th accept → next edge all outputs at reset values. A fresh `start` then completes a full 8-quad frame.
